// File: rtl/updown_timer_nch_if.sv
// Bus bundle for updown_timer_nch: preset writes, per-channel start/pause/stop controls,
// and the status and count outputs. master drives controls, slave is the timer bank.
interface updown_timer_nch_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 preset_wr;
    logic [CH_W-1:0]      preset_ch;
    logic [WIDTH-1:0]     preset_value;
    logic [NCH-1:0]       start_up;
    logic [NCH-1:0]       start_dn;
    logic [NCH-1:0]       pause;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       expired;
    logic                 any_expired;
    logic [NCH*WIDTH-1:0] count_bus;

    modport master (
        output preset_wr, preset_ch, preset_value, start_up, start_dn, pause, stop,
        input  busy, expired, any_expired, count_bus
    );

    modport slave (
        input  preset_wr, preset_ch, preset_value, start_up, start_dn, pause, stop,
        output busy, expired, any_expired, count_bus
    );
endinterface

// File: rtl/updown_timer_nch.sv
// NCH-channel WIDTH-bit up/down expiry timer bank with per-channel presets and one-cycle expiry pulses.
// Define UDTMR_AUTO_RELOAD_EN for periodic mode (reload at terminal count instead of one-shot expiry).
module updown_timer_nch #(
    parameter int WIDTH          = 8,
    parameter int NCH            = 4,
    parameter int DEFAULT_PRESET = 200
) (
    input logic               clk,
    input logic               reset,
    updown_timer_nch_if.slave bus
);
    localparam logic [WIDTH-1:0] PRESET_INIT = WIDTH'(DEFAULT_PRESET);

    typedef enum logic [1:0] {
        IDLE,
        RUN_UP,
        RUN_DN,
        EXPIRED
    } state_t;

    state_t               state_q  [NCH];
    logic [WIDTH-1:0]     count_q  [NCH];
    logic [WIDTH-1:0]     target_q [NCH];
    logic [WIDTH-1:0]     preset_q [NCH];
    logic [NCH-1:0]       up_q;
    logic [NCH-1:0]       dn_q;
    logic [NCH-1:0]       busy_q;
    logic [NCH-1:0]       expired_q;
    logic [NCH-1:0]       rise_up;
    logic [NCH-1:0]       rise_dn;
    logic [NCH*WIDTH-1:0] count_flat;

    assign rise_up = bus.start_up & ~up_q;
    assign rise_dn = bus.start_dn & ~dn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q      <= '0;
            dn_q      <= '0;
            busy_q    <= '0;
            expired_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i]  <= IDLE;
                count_q[i]  <= '0;
                target_q[i] <= '0;
                preset_q[i] <= PRESET_INIT;
            end
        end else begin
            up_q <= bus.start_up;
            dn_q <= bus.start_dn;
            if (bus.preset_wr && (int'(bus.preset_ch) < NCH)) begin
                preset_q[bus.preset_ch] <= bus.preset_value;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                expired_q[i] <= 1'b0;
                // Priority: stop, then start edges (up before down), then pause, then counting.
                if (bus.stop[i]) begin
                    state_q[i] <= IDLE;
                    busy_q[i]  <= 1'b0;
                end else if (rise_up[i]) begin
                    state_q[i]  <= RUN_UP;
                    busy_q[i]   <= 1'b1;
                    count_q[i]  <= '0;
                    target_q[i] <= preset_q[i];
                end else if (rise_dn[i]) begin
                    state_q[i] <= RUN_DN;
                    busy_q[i]  <= 1'b1;
                    count_q[i] <= preset_q[i];
                end else begin
                    case (state_q[i])
                        RUN_UP: begin
                            if (!bus.pause[i]) begin
                                if (count_q[i] == target_q[i]) begin
                                    expired_q[i] <= 1'b1;
`ifdef UDTMR_AUTO_RELOAD_EN
                                    count_q[i]  <= '0;
                                    target_q[i] <= preset_q[i];
`else
                                    state_q[i] <= EXPIRED;
                                    busy_q[i]  <= 1'b0;
`endif
                                end else begin
                                    count_q[i] <= count_q[i] + 1'b1;
                                end
                            end
                        end
                        RUN_DN: begin
                            if (!bus.pause[i]) begin
                                if (count_q[i] == '0) begin
                                    expired_q[i] <= 1'b1;
`ifdef UDTMR_AUTO_RELOAD_EN
                                    count_q[i] <= preset_q[i];
`else
                                    state_q[i] <= EXPIRED;
                                    busy_q[i]  <= 1'b0;
`endif
                                end else begin
                                    count_q[i] <= count_q[i] - 1'b1;
                                end
                            end
                        end
                        EXPIRED: state_q[i] <= IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        count_flat = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            count_flat[i*WIDTH +: WIDTH] = count_q[i];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.expired     = expired_q;
    assign bus.any_expired = |expired_q;
    assign bus.count_bus   = count_flat;
endmodule
